// File: rtl/cp0_trap_ctrl.sv
// ----------------------------------------------------------------------------
// cp0_trap_ctrl
//
// CP0 trap sequencer for the single-cycle CPU. Holds Status (reg 12),
// Cause (reg 13) and EPC (reg 14), serves mfc0/mtc0, and tells the PC-select
// mux each cycle whether to follow the sequential path, jump to the trap
// vector or return through EPC on eret.
//
// Ports
//   clk        in   system clock, rising edge
//   clrn       in   asynchronous active-low reset
//   pc         in   address of the instruction executing this cycle
//   is_mfc0    in   decoded mfc0
//   is_mtc0    in   decoded mtc0
//   is_eret    in   decoded eret
//   cp0_rd     in   CP0 register select (rd field)
//   cp0_wdata  in   mtc0 write data (rt value)
//   ov         in   ALU overflow on a trapping add/sub/addi
//   intr       in   asynchronous external interrupt level
//   cp0_rdata  out  mfc0 read data (combinational)
//   pc_redir   out  next PC comes from pc_target
//   pc_target  out  VECTOR on a trap, EPC on eret
//   wb_kill    out  suppress GPR/memory write of the current instruction
//   inta       out  one-cycle interrupt acknowledge (registered)
//   status     out  Status register (bit 9 = IE, bit 1 = EXL)
// ----------------------------------------------------------------------------
module cp0_trap_ctrl #(
   parameter logic [31:0] VECTOR      = 32'h0000_0054,
   parameter logic [4:0]  EXC_OV      = 5'd12,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] pc,
   input  logic        is_mfc0,
   input  logic        is_mtc0,
   input  logic        is_eret,
   input  logic [4:0]  cp0_rd,
   input  logic [31:0] cp0_wdata,
   input  logic        ov,
   input  logic        intr,
   output logic [31:0] cp0_rdata,
   output logic        pc_redir,
   output logic [31:0] pc_target,
   output logic        wb_kill,
   output logic        inta,
   output logic [31:0] status
);

   localparam logic [4:0] RD_STATUS = 5'd12;
   localparam logic [4:0] RD_CAUSE  = 5'd13;
   localparam logic [4:0] RD_EPC    = 5'd14;

   // EXL is the only state bit; the enum just gives it readable names.
   typedef enum logic {
      RUN     = 1'b0,
      HANDLER = 1'b1
   } trap_state_e;

   logic [31:0]            status_q, status_d;
   logic [31:0]            cause_q, cause_d;
   logic [31:0]            epc_q, epc_d;
   logic                   pending_q, pending_d;
   logic [SYNC_STAGES-1:0] syncChain_q;
   logic                   intrLevelPrev_q;
   logic                   inta_q;

   trap_state_e            trapState;
   logic                   intrLevel;
   logic                   intrRise;
   logic                   takeOv;
   logic                   takeInt;
   logic                   trap;

   // The interrupt is only eligible outside the handler and never in the
   // same cycle as an eret or an overflow; overflow wins and the interrupt
   // simply stays pending.
   always_comb begin
      trapState = trap_state_e'(status_q[1]);
      intrLevel = syncChain_q[SYNC_STAGES-1];
      intrRise  = intrLevel & ~intrLevelPrev_q;
      takeOv    = ov;
      takeInt   = pending_q & status_q[9] & (trapState == RUN) & ~is_eret & ~ov;
      trap      = takeOv | takeInt;
   end

   // PC steering and write-back suppression for the current instruction.
   always_comb begin
      pc_redir  = trap | is_eret;
      pc_target = trap ? VECTOR : epc_q;
      wb_kill   = trap;
   end

   // mfc0 reads the pre-edge register value, so a same-cycle mtc0 is not seen.
   always_comb begin
      cp0_rdata = 32'h0;
      if (is_mfc0) begin
         case (cp0_rd)
            RD_STATUS: cp0_rdata = status_q;
            RD_CAUSE:  cp0_rdata = cause_q;
            RD_EPC:    cp0_rdata = epc_q;
            default:   cp0_rdata = 32'h0;
         endcase
      end
   end

   // Next-state for the CP0 registers. A trap suppresses any mtc0 in the
   // same cycle; an mtc0 to Status can override EXL directly. A rising edge
   // arriving in the acceptance cycle is kept rather than lost.
   always_comb begin
      status_d  = status_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      pending_d = intrRise | (pending_q & ~takeInt);
      if (trap) begin
         status_d[1] = 1'b1;
         epc_d       = pc;
         cause_d     = takeOv ? {25'b0, EXC_OV, 2'b00} : 32'h0;
      end else begin
         if (is_mtc0) begin
            case (cp0_rd)
               RD_STATUS: status_d = cp0_wdata;
               RD_CAUSE:  cause_d  = cp0_wdata;
               RD_EPC:    epc_d    = cp0_wdata;
               default:   ;
            endcase
         end
         if (is_eret) begin
            status_d[1] = 1'b0;
         end
      end
   end

   // All state, including the interrupt synchronizer and the registered
   // acknowledge, clears asynchronously so a reset inside the handler drops
   // back to RUN with interrupts disabled and nothing pending.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         status_q        <= 32'h0;
         cause_q         <= 32'h0;
         epc_q           <= 32'h0;
         pending_q       <= 1'b0;
         syncChain_q     <= '0;
         intrLevelPrev_q <= 1'b0;
         inta_q          <= 1'b0;
      end else begin
         status_q        <= status_d;
         cause_q         <= cause_d;
         epc_q           <= epc_d;
         pending_q       <= pending_d;
         syncChain_q     <= {syncChain_q[SYNC_STAGES-2:0], intr};
         intrLevelPrev_q <= intrLevel;
         inta_q          <= takeInt;
      end
   end

   assign inta   = inta_q;
   assign status = status_q;

endmodule

// File: tb/tb_cp0_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cp0_trap_ctrl
//
// Directed bench for cp0_trap_ctrl: a table of single-cycle vectors for the
// mfc0/mtc0/overflow/eret paths, then hand-written sequences for interrupt
// synchronization, IE gating, overflow/interrupt collision and reset inside
// the handler.
// ----------------------------------------------------------------------------
module tb_cp0_trap_ctrl;

   logic        clk;
   logic        clrn;
   logic [31:0] pc;
   logic        is_mfc0;
   logic        is_mtc0;
   logic        is_eret;
   logic [4:0]  cp0_rd;
   logic [31:0] cp0_wdata;
   logic        ov;
   logic        intr;
   logic [31:0] cp0_rdata;
   logic        pc_redir;
   logic [31:0] pc_target;
   logic        wb_kill;
   logic        inta;
   logic [31:0] status;

   int checks;
   int failures;

   typedef struct {
      logic        mfc0;
      logic        mtc0;
      logic        eret;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        ovIn;
      logic [31:0] pcIn;
      logic        expRedir;
      logic [31:0] expTarget;
      logic        expKill;
      logic [31:0] expStatus;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs [18];

   cp0_trap_ctrl dut (
      .clk       (clk),
      .clrn      (clrn),
      .pc        (pc),
      .is_mfc0   (is_mfc0),
      .is_mtc0   (is_mtc0),
      .is_eret   (is_eret),
      .cp0_rd    (cp0_rd),
      .cp0_wdata (cp0_wdata),
      .ov        (ov),
      .intr      (intr),
      .cp0_rdata (cp0_rdata),
      .pc_redir  (pc_redir),
      .pc_target (pc_target),
      .wb_kill   (wb_kill),
      .inta      (inta),
      .status    (status)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one instruction cycle just after the rising edge, then waits for
   // the falling edge so the combinational outputs can be sampled.
   task automatic applyStimulus(input logic m, input logic t, input logic e,
                                input logic [4:0] r, input logic [31:0] w,
                                input logic o, input logic [31:0] p, input logic irq);
      @(posedge clk);
      #1;
      is_mfc0   = m;
      is_mtc0   = t;
      is_eret   = e;
      cp0_rd    = r;
      cp0_wdata = w;
      ov        = o;
      pc        = p;
      intr      = irq;
      @(negedge clk);
   endtask

   // Compares the control outputs; target and read data only when relevant.
   task automatic checkOutput(input string name, input logic expRedir, input logic [31:0] expTarget,
                              input logic expKill, input logic expInta, input logic [31:0] expStatus,
                              input logic chkTarget, input logic chkRdata, input logic [31:0] expRdata);
      checkVal({name, " pc_redir"}, {31'b0, pc_redir}, {31'b0, expRedir});
      checkVal({name, " wb_kill"}, {31'b0, wb_kill}, {31'b0, expKill});
      checkVal({name, " inta"}, {31'b0, inta}, {31'b0, expInta});
      checkVal({name, " status"}, status, expStatus);
      if (chkTarget) checkVal({name, " pc_target"}, pc_target, expTarget);
      if (chkRdata) checkVal({name, " cp0_rdata"}, cp0_rdata, expRdata);
   endtask

   task automatic idleCycles(input string name, input int n, input logic [31:0] startPc,
                             input logic irq, input logic [31:0] expStatus);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, startPc + 32'(4 * k), irq);
         checkOutput($sformatf("%s idle%0d", name, k), 1'b0, 32'h0, 1'b0, 1'b0, expStatus,
                     1'b0, 1'b0, 32'h0);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      clrn      = 1'b0;
      pc        = 32'h0;
      is_mfc0   = 1'b1;
      is_mtc0   = 1'b0;
      is_eret   = 1'b0;
      cp0_rd    = 5'd13;
      cp0_wdata = 32'h0;
      ov        = 1'b0;
      intr      = 1'b1;

      // Reset held for three cycles with the interrupt line high.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("reset%0d", k), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      end
      @(posedge clk);
      #1;
      clrn = 1'b1;
      is_mfc0 = 1'b0;

      // IE=0, so the synchronized edge only sets pending; nothing traps.
      idleCycles("postreset", 5, 32'h0, 1'b1, 32'h0);

      // Reset again to drop that pending interrupt.
      @(posedge clk);
      #1;
      clrn = 1'b0;
      intr = 1'b0;
      @(negedge clk);
      checkOutput("reset2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      clrn = 1'b1;

      //             mfc0  mtc0  eret  rd     wdata         ov    pc            redir target        kill  status        rdata
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd12, 32'h0,         1'b0, 32'h0000_0004, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 32'h0000_0200};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd5,  32'h0000_FFFF, 1'b0, 32'h0000_0008, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h0,         1'b0, 32'h0000_000C, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_0054, 1'b1, 32'h0000_0200, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd14, 32'h0,         1'b0, 32'h0000_0054, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0000_0014};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd13, 32'h0,         1'b0, 32'h0000_0058, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0000_0030};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd13, 32'h0000_0ABC, 1'b0, 32'h0000_005C, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0123, 1'b0, 32'h0000_0060, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0000_0ABC};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd13, 32'h0,         1'b0, 32'h0000_0064, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0000_0123};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,         1'b0, 32'h0000_0078, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0202, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 5'd12, 32'h0,         1'b0, 32'h0000_0014, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 32'h0000_0200};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_0040, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0054, 1'b1, 32'h0000_0200, 32'h0000_0014};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 5'd14, 32'h0,         1'b0, 32'h0000_0054, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0000_0018};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0058, 1'b1, 32'h0000_0054, 1'b1, 32'h0000_0202, 32'h0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 5'd14, 32'h0,         1'b0, 32'h0000_0054, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0000_0058};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_0200, 1'b0, 32'h0000_005C, 1'b0, 32'h0,         1'b0, 32'h0000_0202, 32'h0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 5'd12, 32'h0,         1'b0, 32'h0000_0060, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 32'h0000_0200};

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].mfc0, vecs[i].mtc0, vecs[i].eret, vecs[i].rd, vecs[i].wdata,
                       vecs[i].ovIn, vecs[i].pcIn, 1'b0);
         checkOutput($sformatf("vec%0d", i), vecs[i].expRedir, vecs[i].expTarget, vecs[i].expKill,
                     1'b0, vecs[i].expStatus, vecs[i].expRedir, 1'b1, vecs[i].expRdata);
      end

      // Interrupt with IE=1: trap lands SYNC_STAGES+1 cycles after intr rises.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h100 + 32'(4 * k), 1'b1);
         checkOutput($sformatf("irq cyc%0d", k), k == 3, 32'h54, k == 3, 1'b0, 32'h200,
                     k == 3, 1'b0, 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd14, 32'h0, 1'b0, 32'h54, 1'b1);
      checkOutput("irq epc", 1'b0, 32'h0, 1'b0, 1'b1, 32'h202, 1'b0, 1'b1, 32'h10C);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 1'b0, 32'h58, 1'b1);
      checkOutput("irq cause", 1'b0, 32'h0, 1'b0, 1'b0, 32'h202, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 32'h5C, 1'b1);
      checkOutput("irq eret", 1'b1, 32'h10C, 1'b0, 1'b0, 32'h202, 1'b1, 1'b0, 32'h0);
      idleCycles("irq held", 6, 32'h10C, 1'b1, 32'h200);

      // IE=0: a pulse only leaves the interrupt pending until IE is set.
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h0, 1'b0, 32'h200, 1'b0);
      idleCycles("ie0 drain", 3, 32'h204, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h210, 1'b1);
      idleCycles("ie0 pulse", 6, 32'h214, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h200, 1'b0, 32'h300, 1'b0);
      checkOutput("ie set", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h304, 1'b0);
      checkOutput("ie trap", 1'b1, 32'h54, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd14, 32'h0, 1'b0, 32'h54, 1'b0);
      checkOutput("ie epc", 1'b0, 32'h0, 1'b0, 1'b1, 32'h202, 1'b0, 1'b1, 32'h304);
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 32'h58, 1'b0);
      checkOutput("ie eret", 1'b1, 32'h304, 1'b0, 1'b0, 32'h202, 1'b1, 1'b0, 32'h0);

      // Overflow collides with an eligible interrupt: overflow first, then the interrupt.
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h0, 1'b0, 32'h308, 1'b0);
      idleCycles("col drain", 3, 32'h30C, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h318, 1'b1);
      idleCycles("col pulse", 6, 32'h31C, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h200, 1'b0, 32'h20, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h24, 1'b0);
      checkOutput("col ov", 1'b1, 32'h54, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 1'b0, 32'h54, 1'b0);
      checkOutput("col cause", 1'b0, 32'h0, 1'b0, 1'b0, 32'h202, 1'b0, 1'b1, 32'h30);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd14, 32'h0, 1'b0, 32'h58, 1'b0);
      checkOutput("col epc", 1'b0, 32'h0, 1'b0, 1'b0, 32'h202, 1'b0, 1'b1, 32'h24);
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 32'h80, 1'b0);
      checkOutput("col eret", 1'b1, 32'h24, 1'b0, 1'b0, 32'h202, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h24, 1'b0);
      checkOutput("col irq", 1'b1, 32'h54, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 1'b0, 32'h54, 1'b0);
      checkOutput("col irq cause", 1'b0, 32'h0, 1'b0, 1'b1, 32'h202, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd14, 32'h0, 1'b0, 32'h58, 1'b0);
      checkOutput("col irq epc", 1'b0, 32'h0, 1'b0, 1'b0, 32'h202, 1'b0, 1'b1, 32'h24);

      // Reset inside the handler with an interrupt pending: pending is lost.
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h5C, 1'b1);
      idleCycles("hnd pulse", 6, 32'h60, 1'b0, 32'h202);
      @(posedge clk);
      #1;
      clrn = 1'b0;
      @(negedge clk);
      checkOutput("hnd reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      clrn = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd12, 32'h200, 1'b0, 32'h0, 1'b0);
      idleCycles("hnd after", 4, 32'h4, 1'b0, 32'h200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
